if_prefetch_queue: RTL
======================

Name: if_prefetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single-register fetch stage. It runs ahead of decode: it issues sequential instruction-memory reads and buffers up to DEPTH {pc, instruction} pairs in a FIFO. It supports decode back-pressure and branch redirect with flush, and sits between instruction memory and the decode stage inside scc.

Parameters:
ADDR_W, 32, PC and memory address width
INSTR_W, 32, instruction width
DEPTH, 4, queue entries (power of two, 2..16)
RESET_PC, 0, first fetch address after reset
PC_STEP, 4, sequential PC increment

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
clk_en  in  1  clock enable; low freezes all state
imem_req  out  1  fetch request strobe, one cycle per request
imem_addr  out  ADDR_W  fetch address, valid while imem_req=1
imem_valid  in  1  response strobe for the oldest outstanding request
imem_data  in  INSTR_W  fetched instruction, valid with imem_valid
redirect  in  1  flush and restart at redirect_pc
redirect_pc  in  ADDR_W  new fetch address
id_valid  out  1  head entry available to decode
id_ready  in  1  decode accepts head this cycle
id_instr  out  INSTR_W  head instruction
id_pc  out  ADDR_W  address of head instruction
count  out  $clog2(DEPTH)+1  occupied entries
err  out  1  sticky fetch error (optional feature only; else tied 0)

Behaviour:
- Reset (async, rst=1) values:
  - fetch_pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; queue empty.
  - count=0; id_valid=0; id_instr=0; id_pc=0; outstanding=0; drop=0; err=0.
- clk_en=0: no state changes; imem_req forced 0; outputs hold.
- Outstanding requests: at most one (outstanding flag).
  - The request is issued in the cycle imem_req=1.
  - Its response arrives on any later cycle with imem_valid=1.
  - Minimum round trip is 1 cycle.
- Push: on imem_valid=1 with drop=0, write {fetch address of that request, imem_data} at the tail.
- Pop: on id_valid && id_ready, advance the head.
- Simultaneous push and pop: count is unchanged. Pop on an empty queue never occurs, because id_valid=0 when empty.
- Issue rule, evaluated each enabled cycle:
  - imem_req=1 iff redirect=0, err=0, and (outstanding=0 or imem_valid=1).
  - Additionally, (count + push − pop) < DEPTH.
  - On issue: imem_addr=fetch_pc; fetch_pc += PC_STEP next cycle (wraps modulo 2^ADDR_W).
  - Back-to-back issue: one instruction per cycle with a 1-cycle memory.
- Full: count=DEPTH implies imem_req=0 until a pop. Entries never overflow, because a slot is reserved at issue time.
- Head outputs:
  - id_valid=(count!=0).
  - id_instr/id_pc come combinationally from the head entry and are 0 when empty.
- Redirect (highest priority):
  - Queue flushed (count=0 next cycle); fetch_pc=redirect_pc; no issue that cycle.
  - A push arriving in the redirect cycle is discarded.
  - Outstanding with no response this cycle: set drop=1; the next imem_valid is discarded and clears drop and outstanding.
  - First fetch from redirect_pc occurs the cycle after the redirect if nothing is outstanding, else the cycle the stale response returns.
- Redirect with id_ready same cycle: the pop is ignored (flush wins).
- Reset mid-request: outstanding and drop cleared. A late imem_valid after reset with outstanding=0 is ignored.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined: a redirect_pc with nonzero low $clog2(PC_STEP) bits sets err=1 (sticky until rst).
  - The queue is flushed; no further requests are issued.
  - Any in-flight response is dropped.
- Undefined: low $clog2(PC_STEP) bits of redirect_pc are forced to 0 silently; err tied 0.

Test Plan:
1. Reset, id_ready=1, 1-cycle memory returning 0x1000_0000+addr: imem_addr 0,4,8,… on consecutive cycles. From cycle 2, id_valid=1 every cycle with id_pc 0,4,8 in order and matching id_instr.
2. id_ready=0, DEPTH=4: exactly 4 requests (0x0–0xC), count=4, imem_req stays 0. Raise id_ready for 1 cycle: count 3, one new request at 0x10.
3. Simultaneous push and pop at count=2: count stays 2 and FIFO order is preserved.
4. Redirect to 0x200 while count=3 and a request is outstanding, with memory latency 3: count=0 next cycle. The stale response is not pushed. The next imem_addr=0x200, issued the cycle the stale response returns; first id_pc=0x200.
5. Assert rst mid-request: all outputs return to reset values immediately. A later imem_valid is ignored, and fetch restarts at RESET_PC.
6. Alignment: with FETCH_ALIGN_CHECK_EN, redirect_pc=0x202 gives err=1, imem_req=0 forever, id_valid=0. Without the macro, fetch resumes at 0x200 and err=0.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue.
// Runs ahead of decode and issues sequential instruction-memory reads, one
// request in flight at a time. Each fetched {pc, instruction} pair is buffered
// in a DEPTH-entry FIFO. Decode drains the FIFO with a valid/ready handshake.
// A redirect flushes the FIFO and restarts fetch at redirect_pc. If a request
// is still in flight, its stale response is marked for discard.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, a misaligned
// redirect_pc raises a sticky err and stops fetching. When it is undefined, the
// low bits of redirect_pc are silently cleared.
module if_prefetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_valid,
  input  logic [INSTR_W-1:0]         imem_data,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [INSTR_W-1:0]         id_instr,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int OCC_W   = CNT_W + 1;
  localparam int ALIGN_W = $clog2(PC_STEP);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << ALIGN_W) - 64'd1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0]  fetch_pc_reg;
  logic [ADDR_W-1:0]  req_pc_reg;      // address of the request in flight
  logic               outstanding_reg;
  logic               drop_reg;        // in-flight response belongs to a flushed stream
  logic               err_reg;
  logic [PTR_W-1:0]   head_reg;
  logic [PTR_W-1:0]   tail_reg;
  logic [CNT_W-1:0]   count_reg;

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic               resp;
  logic               push;
  logic               pop;
  logic               room;
  logic               issue;
  logic [OCC_W-1:0]   occ_next;
  logic [ADDR_W-1:0]  redirect_target;
  logic               err_set;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign;
  assign misalign        = |(redirect_pc & LOW_MASK);
  assign redirect_target = redirect_pc;
  assign err_set         = misalign;
`else
  assign redirect_target = redirect_pc & ~LOW_MASK;
  assign err_set         = 1'b0;
`endif

  // A response only counts when a request is actually in flight. A late strobe after reset is ignored.
  assign resp = imem_valid & outstanding_reg;
  assign push = clk_en & resp & ~drop_reg & ~redirect;
  assign pop  = clk_en & id_valid & id_ready & ~redirect;

  // Reserve a slot at issue time, so the FIFO can never overflow.
  assign occ_next = {1'b0, count_reg} + OCC_W'(push) - OCC_W'(pop);
  assign room     = occ_next < OCC_W'(DEPTH);
  assign issue    = clk_en & ~rst & ~redirect & ~err_reg & (~outstanding_reg | imem_valid) & room;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_reg;
  assign id_valid  = (count_reg != '0);
  assign id_instr  = id_valid ? instr_mem[head_reg] : '0;
  assign id_pc     = id_valid ? pc_mem[head_reg]    : '0;
  assign count     = count_reg;
  assign err       = err_reg;

  // Fetch control, request tracking and FIFO pointers. Redirect has the highest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      req_pc_reg      <= RESET_PC;
      outstanding_reg <= 1'b0;
      drop_reg        <= 1'b0;
      err_reg         <= 1'b0;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
    end else if (clk_en) begin
      if (redirect) begin
        head_reg     <= '0;
        tail_reg     <= '0;
        count_reg    <= '0;
        fetch_pc_reg <= redirect_target;
        if (err_set) begin
          err_reg <= 1'b1;
        end
        if (outstanding_reg && !imem_valid) begin
          drop_reg <= 1'b1;
        end else begin
          outstanding_reg <= 1'b0;
          drop_reg        <= 1'b0;
        end
      end else begin
        tail_reg  <= tail_reg + PTR_W'(push);
        head_reg  <= head_reg + PTR_W'(pop);
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        if (issue) begin
          outstanding_reg <= 1'b1;
          drop_reg        <= 1'b0;
          req_pc_reg      <= fetch_pc_reg;
          fetch_pc_reg    <= fetch_pc_reg + STEP;
        end else if (resp) begin
          outstanding_reg <= 1'b0;
          drop_reg        <= 1'b0;
        end
      end
    end
  end

  // FIFO storage. Contents are only observed through the count-gated head outputs, so they have no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_reg]    <= req_pc_reg;
      instr_mem[tail_reg] <= imem_data;
    end
  end

endmodule
